// File: rtl/kgp_lsu_pkg.sv
// Shared types and helpers for the KGP miniRISC load/store unit.
// Size codes, FSM states, byte-enable generation, store lane
// replication and load-lane extension all live here.
package kgp_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int CNT_W = 4;

    // True when the access size is legal and the low address bits suit it
    function automatic logic is_aligned(input size_t sz, input logic [1:0] low);
        logic ok;
        ok = 1'b0;
        case (sz)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~low[0];
            SZ_WORD: ok = (low == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Little-endian byte enables for the addressed lanes
    function automatic logic [3:0] byte_en(input size_t sz, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (sz)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicates the low store bytes across the word so any lane can pick them up
    function automatic logic [31:0] store_lanes(input size_t sz, input logic [31:0] wd);
        logic [31:0] r;
        r = wd;
        case (sz)
            SZ_BYTE: r = {4{wd[7:0]}};
            SZ_HALF: r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    // Selects the addressed lane of a word and sign- or zero-extends it
    function automatic logic [31:0] extend_load(input logic [31:0] word, input size_t sz,
                                                input logic [1:0] lane, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        r = word;
        case (sz)
            SZ_BYTE: r = {{24{sext & b[7]}}, b};
            SZ_HALF: r = {{16{sext & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/kgp_lsu_if.sv
// Request/response bundle between the CPU datapath and the load/store unit.
// The CPU side is the master; the LSU is the slave.
interface kgp_lsu_if
    import kgp_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int OFF_W  = 16
);
    logic              MemRead;
    logic              MemWrite;
    size_t             size;
    logic              sign_ext;
    logic [ADDR_W-1:0] base;
    logic [OFF_W-1:0]  offset;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output MemRead, MemWrite, size, sign_ext, base, offset, wdata,
        input  busy, done, rdata, err
    );

    modport slave (
        input  MemRead, MemWrite, size, sign_ext, base, offset, wdata,
        output busy, done, rdata, err
    );
endinterface

// File: rtl/kgp_lsu_sram.sv
// DEPTH x DATA_W synchronous RAM with per-byte write enables and a single
// registered read port sharing the write address. Contents are not reset.
module kgp_lsu_sram #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [IDX_W-1:0]      addr,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-masked write and read-before-write registered read
    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_W/8; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/kgp_lsu.sv
// KGP miniRISC load/store unit: effective-address generation, alignment
// checking, LAT wait states, byte/half/word access with extension, and a
// private data RAM. busy stalls the PC while an access is in flight.
module kgp_lsu
    import kgp_lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int OFF_W  = 16,
    parameter int DEPTH  = 1024,
    parameter int LAT    = 2
) (
    input  logic     clk,
    input  logic     rst,
    kgp_lsu_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int EA_W  = IDX_W + 2;

    logic [ADDR_W-1:0] ea_now;
    logic              req_any;
    logic              legal_req;
    logic              unused_ea_hi;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [EA_W-1:0]   ea_lat;
    size_t             size_lat;
    logic              sext_lat;
    logic              wr_lat;
    logic [DATA_W-1:0] wdata_lat;

    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic [IDX_W-1:0]  ram_addr;
    logic [3:0]        ram_be;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q;

    assign ea_now       = bus.base + {{(ADDR_W-OFF_W){bus.offset[OFF_W-1]}}, bus.offset};
    assign unused_ea_hi = ^ea_now[ADDR_W-1:EA_W];
    assign req_any      = bus.MemRead | bus.MemWrite;
    assign legal_req    = (bus.MemRead ^ bus.MemWrite) && is_aligned(bus.size, ea_now[1:0]);

    assign ram_addr  = (state == IDLE) ? ea_now[EA_W-1:2] : ea_lat[EA_W-1:2];
    assign ram_be    = (state == DONE && wr_lat) ? byte_en(size_lat, ea_lat[1:0]) : 4'b0000;
    assign ram_wdata = store_lanes(size_lat, wdata_lat);

    kgp_lsu_sram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_sram (
        .clk   (clk),
        .addr  (ram_addr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    // Access FSM: latch a legal request in IDLE, count wait states, then complete in DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ea_lat    <= '0;
            size_lat  <= SZ_BYTE;
            sext_lat  <= 1'b0;
            wr_lat    <= 1'b0;
            wdata_lat <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (legal_req) begin
                        ea_lat    <= ea_now[EA_W-1:0];
                        size_lat  <= bus.size;
                        sext_lat  <= bus.sign_ext;
                        wr_lat    <= bus.MemWrite;
                        wdata_lat <= bus.wdata;
                        cnt       <= CNT_W'(LAT);
                        busy_q    <= 1'b1;
                        state     <= (LAT == 0) ? DONE : WAIT;
                    end else if (req_any) begin
                        err_q <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!wr_lat) begin
                        rdata_q <= extend_load(ram_q, size_lat, ea_lat[1:0], sext_lat);
                    end
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_kgp_lsu.sv
// Directed bench for kgp_lsu: one instance with LAT=2 and one with LAT=0.
// Expected completions are queued as each request is driven and compared
// when the unit responds.
module tb_kgp_lsu;
    import kgp_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    kgp_lsu_if #(.ADDR_W(32), .DATA_W(32), .OFF_W(16)) bus2 ();
    kgp_lsu_if #(.ADDR_W(32), .DATA_W(32), .OFF_W(16)) bus0 ();

    kgp_lsu #(.DATA_W(32), .ADDR_W(32), .OFF_W(16), .DEPTH(1024), .LAT(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    kgp_lsu #(.DATA_W(32), .ADDR_W(32), .OFF_W(16), .DEPTH(1024), .LAT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    typedef struct {
        string       tag;
        bit          sel0;
        bit          is_err;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_rd2 = 32'h0;
    logic [31:0] last_rd0 = 32'h0;

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic drive_bus(input bit sel0, input logic rd, input logic wr, input size_t sz,
                             input logic sx, input logic [31:0] b, input logic [15:0] off,
                             input logic [31:0] wd);
        if (sel0) begin
            bus0.MemRead = rd; bus0.MemWrite = wr; bus0.size = sz; bus0.sign_ext = sx;
            bus0.base = b; bus0.offset = off; bus0.wdata = wd;
        end else begin
            bus2.MemRead = rd; bus2.MemWrite = wr; bus2.size = sz; bus2.sign_ext = sx;
            bus2.base = b; bus2.offset = off; bus2.wdata = wd;
        end
    endtask

    task automatic sample_bus(input bit sel0, output logic b, output logic d, output logic e,
                              output logic [31:0] r);
        if (sel0) begin
            b = bus0.busy; d = bus0.done; e = bus0.err; r = bus0.rdata;
        end else begin
            b = bus2.busy; d = bus2.done; e = bus2.err; r = bus2.rdata;
        end
    endtask

    // Drive one request, queue its expected outcome, let the accept edge pass,
    // then scramble the non-strobe inputs to show the latched copy is used.
    task automatic applyStimulus(input string tag, input bit sel0, input logic rd, input logic wr,
                                 input size_t sz, input logic sx, input logic [31:0] b,
                                 input logic [15:0] off, input logic [31:0] wd,
                                 input bit exp_err, input logic [31:0] exp_data);
        exp_t x;
        x.tag    = tag;
        x.sel0   = sel0;
        x.is_err = exp_err;
        x.lat    = sel0 ? 1 : 3;
        if (!exp_err && rd && !wr) begin
            if (sel0) last_rd0 = exp_data;
            else      last_rd2 = exp_data;
        end
        x.data = sel0 ? last_rd0 : last_rd2;
        sb_q.push_back(x);
        drive_bus(sel0, rd, wr, sz, sx, b, off, wd);
        @(posedge clk);
        #1;
        drive_bus(sel0, 1'b0, 1'b0, SZ_BYTE, ~sx, 32'hFFFF_FFF0, 16'h7FF0, 32'hA5A5_A5A5);
    endtask

    // Pop the oldest expectation and wait (bounded) for the matching response
    task automatic checkOutput();
        exp_t        x;
        logic        b, d, e;
        logic [31:0] r;
        int          k;
        bit          seen;
        x = sb_q.pop_front();
        sample_bus(x.sel0, b, d, e, r);
        check_value({x.tag, "-err"},   {31'b0, e}, {31'b0, x.is_err});
        check_value({x.tag, "-busy0"}, {31'b0, b}, {31'b0, !x.is_err});
        check_value({x.tag, "-done0"}, {31'b0, d}, 32'h0);
        if (!x.is_err) begin
            seen = 1'b0;
            k    = 0;
            while (!seen && k < 20) begin
                @(posedge clk);
                #1;
                k++;
                sample_bus(x.sel0, b, d, e, r);
                seen = d;
            end
            check_value({x.tag, "-lat"},  k, x.lat);
            check_value({x.tag, "-busy"}, {31'b0, b}, 32'h0);
        end
        check_value({x.tag, "-rdata"}, r, x.data);
    endtask

    task automatic do_access(input string tag, input bit sel0, input logic rd, input logic wr,
                             input size_t sz, input logic sx, input logic [31:0] b,
                             input logic [15:0] off, input logic [31:0] wd,
                             input bit exp_err, input logic [31:0] exp_data);
        applyStimulus(tag, sel0, rd, wr, sz, sx, b, off, wd, exp_err, exp_data);
        checkOutput();
    endtask

    initial begin
        rst = 1'b0;
        drive_bus(1'b0, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 16'h0, 32'h0);
        drive_bus(1'b1, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 16'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check_value("rst2-busy",  {31'b0, bus2.busy}, 32'h0);
        check_value("rst2-done",  {31'b0, bus2.done}, 32'h0);
        check_value("rst2-err",   {31'b0, bus2.err},  32'h0);
        check_value("rst2-rdata", bus2.rdata, 32'h0);
        check_value("rst0-busy",  {31'b0, bus0.busy}, 32'h0);
        check_value("rst0-rdata", bus0.rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] word, byte and half accesses, LAT=2");
        do_access("sw_fc",   0, 0, 1, SZ_WORD, 0, 32'h0000_0100, 16'hFFFC, 32'hDEAD_BEEF, 0, 32'h0);
        do_access("lw_fc",   0, 1, 0, SZ_WORD, 0, 32'h0000_00F0, 16'h000C, 32'h0, 0, 32'hDEAD_BEEF);
        do_access("lb_ff_s", 0, 1, 0, SZ_BYTE, 1, 32'h0000_00FF, 16'h0000, 32'h0, 0, 32'hFFFF_FFDE);
        do_access("lb_ff_z", 0, 1, 0, SZ_BYTE, 0, 32'h0000_00FF, 16'h0000, 32'h0, 0, 32'h0000_00DE);
        do_access("lh_fe_s", 0, 1, 0, SZ_HALF, 1, 32'h0000_00FE, 16'h0000, 32'h0, 0, 32'hFFFF_DEAD);
        do_access("sw_100",  0, 0, 1, SZ_WORD, 0, 32'h0000_0104, 16'hFFFC, 32'hDEAD_BEEF, 0, 32'h0);
        do_access("sb_101",  0, 0, 1, SZ_BYTE, 0, 32'h0000_0101, 16'h0000, 32'h1234_5655, 0, 32'h0);
        do_access("lw_100",  0, 1, 0, SZ_WORD, 0, 32'h0000_0100, 16'h0000, 32'h0, 0, 32'hDEAD_55EF);
        do_access("lh_100z", 0, 1, 0, SZ_HALF, 0, 32'h0000_0100, 16'h0000, 32'h0, 0, 32'h0000_55EF);
        do_access("lb_101s", 0, 1, 0, SZ_BYTE, 1, 32'h0000_0101, 16'h0000, 32'h0, 0, 32'h0000_0055);

        $display("[TB] illegal and misaligned requests");
        do_access("e_w102",  0, 0, 1, SZ_WORD, 0, 32'h0000_0102, 16'h0000, 32'h0000_0000, 1, 32'h0);
        do_access("e_h101",  0, 0, 1, SZ_HALF, 0, 32'h0000_0101, 16'h0000, 32'hFFFF_FFFF, 1, 32'h0);
        do_access("e_rw",    0, 1, 1, SZ_WORD, 0, 32'h0000_0100, 16'h0000, 32'h0000_0000, 1, 32'h0);
        do_access("e_sz3",   0, 0, 1, SZ_ILL,  0, 32'h0000_0100, 16'h0000, 32'h0000_0000, 1, 32'h0);
        do_access("lw_100b", 0, 1, 0, SZ_WORD, 0, 32'h0000_0100, 16'h0000, 32'h0, 0, 32'hDEAD_55EF);
        do_access("sh_102",  0, 0, 1, SZ_HALF, 0, 32'h0000_0102, 16'h0000, 32'h9999_CAFE, 0, 32'h0);
        do_access("lw_100c", 0, 1, 0, SZ_WORD, 0, 32'h0000_0100, 16'h0000, 32'h0, 0, 32'hCAFE_55EF);
        do_access("sw_200",  0, 0, 1, SZ_WORD, 0, 32'h0000_0200, 16'h0000, 32'h1122_3344, 0, 32'h0);

        $display("[TB] reset during a store wait state");
        drive_bus(1'b0, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h0000_0200, 16'h0000, 32'hAAAA_5555);
        @(posedge clk);
        #1;
        drive_bus(1'b0, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 16'h0, 32'h0);
        check_value("abort-busy-pre", {31'b0, bus2.busy}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_value("abort-busy",  {31'b0, bus2.busy}, 32'h0);
        check_value("abort-done",  {31'b0, bus2.done}, 32'h0);
        check_value("abort-rdata", bus2.rdata, 32'h0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check_value("abort-nodone", {31'b0, bus2.done}, 32'h0);
        end
        @(negedge clk);
        rst      = 1'b1;
        last_rd2 = 32'h0;
        last_rd0 = 32'h0;
        @(posedge clk);
        #1;
        do_access("lw_200",  0, 1, 0, SZ_WORD, 0, 32'h0000_0200, 16'h0000, 32'h0, 0, 32'h1122_3344);
        do_access("lw_100d", 0, 1, 0, SZ_WORD, 0, 32'h0000_0100, 16'h0000, 32'h0, 0, 32'hCAFE_55EF);

        $display("[TB] LAT=0 instance and address wrap");
        do_access("z_sw1000", 1, 0, 1, SZ_WORD, 0, 32'h0000_1000, 16'h0000, 32'h0BAD_F00D, 0, 32'h0);
        do_access("z_lw0",    1, 1, 0, SZ_WORD, 0, 32'h0000_0000, 16'h0000, 32'h0, 0, 32'h0BAD_F00D);
        do_access("z_lb3s",   1, 1, 0, SZ_BYTE, 1, 32'h0000_0003, 16'h0000, 32'h0, 0, 32'h0000_000B);
        do_access("z_e1003",  1, 1, 0, SZ_HALF, 1, 32'h0000_1003, 16'h0000, 32'h0, 1, 32'h0);
        do_access("z_lh1002", 1, 1, 0, SZ_HALF, 1, 32'h0000_1004, 16'hFFFE, 32'h0, 0, 32'h0000_0BAD);

        @(posedge clk);
        #1;
        check_value("end0-done", {31'b0, bus0.done}, 32'h0);
        check_value("end0-busy", {31'b0, bus0.busy}, 32'h0);
        check_value("end2-err",  {31'b0, bus2.err},  32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
